// File: rtl/rx_word_assembler_if.sv
// ---------------------------------------------------------------------------
// rx_word_assembler_if
//   Bundles the byte-in / word-out signals of rx_word_assembler.
//   Byte side : rx_done (1-cycle strobe), rx_data[7:0]
//   Word side : addr_8[7:0], data_32[31:0], data_vld, data_ack
//   Status    : overrun, timeout_err (1-cycle pulses), busy
//   slave  modport : the assembler itself
//   master modport : UART receiver + word consumer side
// ---------------------------------------------------------------------------
interface rx_word_assembler_if;
    logic        rx_done;
    logic [7:0]  rx_data;
    logic        data_ack;
    logic [7:0]  addr_8;
    logic [31:0] data_32;
    logic        data_vld;
    logic        overrun;
    logic        timeout_err;
    logic        busy;

    modport slave (
        input  rx_done, rx_data, data_ack,
        output addr_8, data_32, data_vld, overrun, timeout_err, busy
    );

    modport master (
        output rx_done, rx_data, data_ack,
        input  addr_8, data_32, data_vld, overrun, timeout_err, busy
    );
endinterface

// File: rtl/rx_word_assembler.sv
// ---------------------------------------------------------------------------
// rx_word_assembler
//   Collects 5-byte frames (1 address byte + 4 data bytes) from a UART
//   receiver and presents them as one address/word pair with a valid/ack
//   handshake. A partial frame is dropped if the gap between bytes exceeds
//   TIMEOUT cycles; bytes arriving while a word is still pending are dropped
//   and flagged as overrun.
//   Ports:
//     Clk    : system clock, rising edge
//     Rst_n  : asynchronous active-low reset
//     bus    : rx_word_assembler_if.slave (rx_done, rx_data, data_ack in;
//              addr_8, data_32, data_vld, overrun, timeout_err, busy out)
//   Parameters:
//     TIMEOUT   : max idle cycles between bytes of one frame
//     MSB_FIRST : 1 -> first data byte lands in data_32[31:24],
//                 0 -> first data byte lands in data_32[7:0]
// ---------------------------------------------------------------------------
module rx_word_assembler #(
    parameter logic [15:0] TIMEOUT   = 16'd50000,
    parameter logic        MSB_FIRST = 1'b1
) (
    input  logic               Clk,
    input  logic               Rst_n,
    rx_word_assembler_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        D0,
        D1,
        D2,
        D3,
        HOLD
    } state_t;

    state_t      r_state;
    logic [15:0] r_cnt;
    // Staging registers: the visible addr_8/data_32 only change when a frame
    // completes, so a timed-out partial frame never disturbs them.
    logic [7:0]  r_addr_stage;
    logic [7:0]  r_b0;
    logic [7:0]  r_b1;
    logic [7:0]  r_b2;
    logic [7:0]  r_addr_8;
    logic [31:0] r_data_32;
    logic        r_data_vld;
    logic        r_overrun;
    logic        r_timeout_err;
    logic        r_busy;
    logic        w_timeout;

    assign w_timeout = (r_cnt == (TIMEOUT - 16'd1));

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_addr_stage  <= '0;
            r_b0          <= '0;
            r_b1          <= '0;
            r_b2          <= '0;
            r_addr_8      <= '0;
            r_data_32     <= '0;
            r_data_vld    <= 1'b0;
            r_overrun     <= 1'b0;
            r_timeout_err <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_overrun     <= 1'b0;
            r_timeout_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    if (bus.rx_done) begin
                        r_addr_stage <= bus.rx_data;
                        r_state      <= D0;
                        r_busy       <= 1'b1;
                    end
                end
                D0, D1, D2, D3: begin
                    // rx_done wins over an expiring counter in the same cycle
                    if (bus.rx_done) begin
                        r_cnt <= '0;
                        case (r_state)
                            D0: begin
                                r_b0    <= bus.rx_data;
                                r_state <= D1;
                            end
                            D1: begin
                                r_b1    <= bus.rx_data;
                                r_state <= D2;
                            end
                            D2: begin
                                r_b2    <= bus.rx_data;
                                r_state <= D3;
                            end
                            default: begin
                                r_addr_8   <= r_addr_stage;
                                r_data_32  <= MSB_FIRST ? {r_b0, r_b1, r_b2, bus.rx_data}
                                                        : {bus.rx_data, r_b2, r_b1, r_b0};
                                r_data_vld <= 1'b1;
                                r_state    <= HOLD;
                            end
                        endcase
                    end else if (w_timeout) begin
                        r_cnt         <= '0;
                        r_timeout_err <= 1'b1;
                        r_busy        <= 1'b0;
                        r_state       <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                HOLD: begin
                    r_cnt <= '0;
                    if (bus.data_ack) begin
                        r_data_vld <= 1'b0;
                        // A byte arriving with the ack starts the next frame
                        if (bus.rx_done) begin
                            r_addr_stage <= bus.rx_data;
                            r_state      <= D0;
                        end else begin
                            r_busy  <= 1'b0;
                            r_state <= IDLE;
                        end
                    end else if (bus.rx_done) begin
                        r_overrun <= 1'b1;
                    end
                end
                default: begin
                    r_cnt   <= '0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.addr_8      = r_addr_8;
    assign bus.data_32     = r_data_32;
    assign bus.data_vld    = r_data_vld;
    assign bus.overrun     = r_overrun;
    assign bus.timeout_err = r_timeout_err;
    assign bus.busy        = r_busy;

endmodule

// File: tb/tb_rx_word_assembler.sv
// ---------------------------------------------------------------------------
// tb_rx_word_assembler
//   Drives two assemblers (MSB_FIRST=1 and MSB_FIRST=0) with identical byte
//   streams and compares both against a frame-level reference model on every
//   cycle, plus directed scenarios with literal expectations.
// ---------------------------------------------------------------------------
module tb_rx_word_assembler;

    localparam logic [15:0] TO = 16'd20;

    logic       Clk      = 1'b0;
    logic       Rst_n    = 1'b0;
    logic       rx_done  = 1'b0;
    logic [7:0] rx_data  = 8'h00;
    logic       data_ack = 1'b0;

    rx_word_assembler_if bus_m ();
    rx_word_assembler_if bus_l ();

    assign bus_m.rx_done  = rx_done;
    assign bus_m.rx_data  = rx_data;
    assign bus_m.data_ack = data_ack;
    assign bus_l.rx_done  = rx_done;
    assign bus_l.rx_data  = rx_data;
    assign bus_l.data_ack = data_ack;

    rx_word_assembler #(.TIMEOUT(TO), .MSB_FIRST(1'b1)) dut_m (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .bus   (bus_m)
    );

    rx_word_assembler #(.TIMEOUT(TO), .MSB_FIRST(1'b0)) dut_l (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .bus   (bus_l)
    );

    always #5 Clk = ~Clk;

    int n_cmp = 0;
    int n_bad = 0;
    int n_ovr = 0;
    int n_to  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- frame-level reference model ----------------
    logic [7:0]  m_frame [0:4];
    int          m_n   = 0;   // bytes of the current frame collected so far
    int          m_gap = 0;   // idle cycles since the last accepted byte
    logic [7:0]  e_addr = 8'h00;
    logic [31:0] e_msb  = 32'h0;
    logic [31:0] e_lsb  = 32'h0;
    bit          e_vld  = 1'b0;
    bit          e_ovr  = 1'b0;
    bit          e_to   = 1'b0;
    bit          e_busy = 1'b0;

    always @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            m_n = 0; m_gap = 0;
            e_addr = 8'h00; e_msb = 32'h0; e_lsb = 32'h0;
            e_vld = 1'b0; e_ovr = 1'b0; e_to = 1'b0; e_busy = 1'b0;
        end else begin
            e_ovr = 1'b0;
            e_to  = 1'b0;
            if (e_vld) begin
                if (data_ack) begin
                    e_vld = 1'b0;
                    if (rx_done) begin
                        m_frame[0] = rx_data; m_n = 1; m_gap = 0;
                    end
                end else if (rx_done) begin
                    e_ovr = 1'b1;
                end
            end else if (m_n == 0) begin
                if (rx_done) begin
                    m_frame[0] = rx_data; m_n = 1; m_gap = 0;
                end
            end else if (rx_done) begin
                m_frame[m_n] = rx_data;
                m_n++;
                m_gap = 0;
                if (m_n == 5) begin
                    e_addr = m_frame[0];
                    e_msb  = {m_frame[1], m_frame[2], m_frame[3], m_frame[4]};
                    e_lsb  = {m_frame[4], m_frame[3], m_frame[2], m_frame[1]};
                    e_vld  = 1'b1;
                    m_n    = 0;
                end
            end else if (m_gap == int'(TO) - 1) begin
                e_to = 1'b1; m_n = 0; m_gap = 0;
            end else begin
                m_gap++;
            end
            e_busy = e_vld || (m_n != 0);
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge Clk) begin
        chk("m.addr_8",      32'(bus_m.addr_8),      32'(e_addr));
        chk("m.data_32",     bus_m.data_32,          e_msb);
        chk("m.data_vld",    32'(bus_m.data_vld),    32'(e_vld));
        chk("m.overrun",     32'(bus_m.overrun),     32'(e_ovr));
        chk("m.timeout_err", 32'(bus_m.timeout_err), 32'(e_to));
        chk("m.busy",        32'(bus_m.busy),        32'(e_busy));
        chk("l.addr_8",      32'(bus_l.addr_8),      32'(e_addr));
        chk("l.data_32",     bus_l.data_32,          e_lsb);
        chk("l.data_vld",    32'(bus_l.data_vld),    32'(e_vld));
        chk("l.overrun",     32'(bus_l.overrun),     32'(e_ovr));
        chk("l.timeout_err", 32'(bus_l.timeout_err), 32'(e_to));
        chk("l.busy",        32'(bus_l.busy),        32'(e_busy));
        if (bus_m.overrun)     n_ovr++;
        if (bus_m.timeout_err) n_to++;
    end

    // ---------------- stimulus helpers (called at posedge+1) ----------------
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_done = 1'b1;
        rx_data = b;
        @(posedge Clk);
        #1;
        rx_done = 1'b0;
        rx_data = 8'($urandom);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, ".addr_8"},      32'(bus_m.addr_8),      32'h0);
        chk({tag, ".data_32"},     bus_m.data_32,          32'h0);
        chk({tag, ".data_vld"},    32'(bus_m.data_vld),    32'h0);
        chk({tag, ".overrun"},     32'(bus_m.overrun),     32'h0);
        chk({tag, ".timeout_err"}, 32'(bus_m.timeout_err), 32'h0);
        chk({tag, ".busy"},        32'(bus_m.busy),        32'h0);
    endtask

    initial begin
        Rst_n = 1'b0;
        idle(2);
        chk_reset_outputs("reset");
        Rst_n = 1'b1;

        // Basic frame, both byte orders; data_vld exactly one cycle after 5th byte
        send_byte(8'h0C); send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE);
        chk("vld_before_5th", 32'(bus_m.data_vld), 32'h0);
        send_byte(8'hEF);
        chk("vld_after_5th", 32'(bus_m.data_vld), 32'h1);
        chk("addr_0C",       32'(bus_m.addr_8),   32'h0C);
        chk("msb_word",      bus_m.data_32,       32'hDEADBEEF);
        chk("lsb_word",      bus_l.data_32,       32'hEFBEADDE);
        chk("model_msb",     e_msb,               32'hDEADBEEF);
        chk("model_lsb",     e_lsb,               32'hEFBEADDE);

        // Overrun while pending
        send_byte(8'h55);
        chk("overrun_pulse", 32'(bus_m.overrun),  32'h1);
        chk("ovr_vld_held",  32'(bus_m.data_vld), 32'h1);
        chk("ovr_word_held", bus_m.data_32,       32'hDEADBEEF);
        idle(1);
        chk("overrun_1cyc",  32'(bus_m.overrun),  32'h0);

        // No timeout while waiting for ack
        n_to = 0;
        idle(int'(TO) + 5);
        chk("hold_no_to",    n_to,                0);
        chk("hold_vld",      32'(bus_m.data_vld), 32'h1);

        // Ack and new address byte in the same cycle
        data_ack = 1'b1;
        send_byte(8'h13);
        data_ack = 1'b0;
        chk("ackrx_vld0",    32'(bus_m.data_vld), 32'h0);
        chk("ackrx_busy",    32'(bus_m.busy),     32'h1);
        chk("ackrx_addr_old",32'(bus_m.addr_8),   32'h0C);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        chk("ackrx_addr",    32'(bus_m.addr_8),   32'h13);
        chk("ackrx_word",    bus_m.data_32,       32'h11223344);
        data_ack = 1'b1;
        idle(1);
        data_ack = 1'b0;
        chk("ack_vld0",      32'(bus_m.data_vld), 32'h0);
        chk("ack_idle",      32'(bus_m.busy),     32'h0);

        // 3-byte frame then silence -> single timeout, outputs untouched
        n_to = 0;
        send_byte(8'h77); send_byte(8'h01); send_byte(8'h02);
        idle(int'(TO) + 2);
        chk("to_count",      n_to,                1);
        chk("to_busy",       32'(bus_m.busy),     32'h0);
        chk("to_addr_kept",  32'(bus_m.addr_8),   32'h13);
        chk("to_word_kept",  bus_m.data_32,       32'h11223344);

        // Next frame, with one byte landing on the last allowed cycle
        n_to = 0;
        send_byte(8'h12); send_byte(8'h00); send_byte(8'h00);
        idle(int'(TO) - 1);
        send_byte(8'h00); send_byte(8'h01);
        chk("edge_no_to",    n_to,                0);
        chk("frame12_addr",  32'(bus_m.addr_8),   32'h12);
        chk("frame12_word",  bus_m.data_32,       32'h00000001);
        data_ack = 1'b1;
        idle(1);
        data_ack = 1'b0;

        // Reset after two data bytes
        send_byte(8'hA0); send_byte(8'h01); send_byte(8'h02);
        Rst_n = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        idle(1);
        Rst_n = 1'b1;
        send_byte(8'h5A); send_byte(8'hCA); send_byte(8'hFE); send_byte(8'hBA); send_byte(8'hBE);
        chk("rst_addr",      32'(bus_m.addr_8),   32'h5A);
        chk("rst_word",      bus_m.data_32,       32'hCAFEBABE);
        chk("rst_vld",       32'(bus_m.data_vld), 32'h1);
        data_ack = 1'b1;
        idle(1);
        data_ack = 1'b0;

        // Randomised traffic against the model
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 149) == 0) begin
                rx_done = 1'b0; data_ack = 1'b0;
                idle(int'($urandom_range(int'(TO) - 2, int'(TO) + 2)));
            end else if ($urandom_range(0, 499) == 0) begin
                Rst_n = 1'b0;
                idle(1);
                Rst_n = 1'b1;
            end
            rx_done  = ($urandom_range(0, 2) == 0);
            rx_data  = 8'($urandom);
            data_ack = ($urandom_range(0, 3) == 0);
            idle(1);
        end
        rx_done = 1'b0;
        data_ack = 1'b0;
        idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rx_word_assembler.md
RX_WORD_ASSEMBLER -- requirements
Module: rx_word_assembler

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16'd50000: maximum idle Clk cycles allowed between bytes of one frame.
REQ-002 SHALL have parameter MSB_FIRST, default 1'b1: 1 means the first data byte maps to data_32[31:24], 0 means it maps to data_32[7:0].
REQ-003 SHALL have port Clk, input, 1: single system clock; all logic is rising-edge.
REQ-004 SHALL have port Rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port rx_done, input, 1: one-cycle pulse marking rx_data valid, driven from the UART receiver.
REQ-006 SHALL have port rx_data, input, 8: received byte, sampled only when rx_done=1.
REQ-007 SHALL have port data_ack, input, 1: consumer accepts the word presented on data_32/addr_8.
REQ-008 SHALL have port addr_8, output, 8: header (address) byte of the completed frame.
REQ-009 SHALL have port data_32, output, 32: assembled payload word.
REQ-010 SHALL have port data_vld, output, 1: asserted while addr_8/data_32 hold an unaccepted word.
REQ-011 SHALL have port overrun, output, 1: one-cycle pulse when a byte is dropped because a word is pending.
REQ-012 SHALL have port timeout_err, output, 1: one-cycle pulse when a partial frame is discarded after a timeout.
REQ-013 SHALL have port busy, output, 1: high in any state other than IDLE.

Function
REQ-014 SHALL treat a frame as exactly 5 bytes: 1 address byte followed by 4 data bytes.
REQ-015 SHALL implement the FSM states IDLE, D0, D1, D2, D3 and HOLD.
- IDLE, on rx_done: latch rx_data into the address register, go to D0.
- Dn, on rx_done: store the byte in its slot; D0 to D1 to D2 to D3; D3 goes to HOLD.
REQ-016 SHALL place bytes when MSB_FIRST=1 as D0 to [31:24], D1 to [23:16], D2 to [15:8], D3 to [7:0]; MSB_FIRST=0 SHALL use the mirrored mapping.
REQ-017 SHALL assert data_vld on the first cycle in HOLD, i.e. one Clk after the rx_done of the 4th data byte.
REQ-018 SHALL keep addr_8 and data_32 stable for the whole time data_vld=1.
REQ-019 SHALL, when in HOLD and data_ack=1, deassert data_vld on the next cycle and return to IDLE.
REQ-020 SHALL ignore data_ack in any state other than HOLD.
REQ-021 SHALL, on rx_done while in HOLD without data_ack, drop the byte, pulse overrun for 1 cycle, and stay in HOLD with the word unchanged.
REQ-022 SHALL, on rx_done and data_ack in the same HOLD cycle, accept the word and treat the byte as a new address byte (next state D0, no overrun).
REQ-023 SHALL use an inter-byte counter that is cleared on every accepted rx_done and on entry to D0, and increments each cycle while in D0 to D3.
REQ-024 SHALL, when the counter reaches TIMEOUT-1 in D0 to D3 without rx_done, go to IDLE, pulse timeout_err for 1 cycle, and leave addr_8/data_32 unchanged.
REQ-025 SHALL give rx_done priority over timeout when both occur in the same cycle (the byte is accepted, no timeout_err).
REQ-026 SHALL not run the counter in IDLE or HOLD (no timeout while waiting for data_ack).
REQ-027 SHALL register all outputs; no output may combinationally depend on any input.

Reset
REQ-028 SHALL, on Rst_n=0, immediately force: state to IDLE, addr_8=8'h00, data_32=32'h0, data_vld=0, overrun=0, timeout_err=0, busy=0, counter=0.
REQ-029 SHALL, on reset mid-frame or in HOLD, discard the partial or pending word, emitting no data_vld and no error pulse.
REQ-030 SHALL accept the first rx_done in the cycle after Rst_n rises.

Verification
REQ-031 SHALL cover: bytes 8'h0C, DE, AD, BE, EF (MSB_FIRST=1) -> addr_8=8'h0C, data_32=32'hDEADBEEF, data_vld=1 exactly 1 cycle after the 5th rx_done.
REQ-032 SHALL cover: the same frame with MSB_FIRST=0 -> data_32=32'hEFBEADDE.
REQ-033 SHALL cover: a 3-byte frame then silence for TIMEOUT cycles -> one timeout_err pulse, busy=0; the next 5 bytes 8'h12, 00, 00, 00, 01 -> addr_8=8'h12, data_32=32'h00000001.
REQ-034 SHALL cover: word pending, data_ack=0, extra byte 8'h55 -> one overrun pulse, data_32 unchanged, data_vld stays 1.
REQ-035 SHALL cover: data_ack and rx_done(8'h13) in the same cycle -> data_vld=0 next cycle, state D0, addr_8 captures 8'h13 at frame completion.
REQ-036 SHALL cover: Rst_n pulsed low after 2 data bytes -> all outputs at reset values; a full frame sent after release assembles correctly.
